pwm_timebase_ctrl: RTL and testbench
====================================

# pwm_timebase_ctrl

Timebase and configuration controller for the PWM generator. It runs the prescaled period counter that produces `count_val`, and drives the generator's `pwm_en`. It holds the active `period`/`functions`/`compare1`/`compare2` set and applies software updates only at a period boundary, so a PWM cycle never sees a half-applied configuration. It sits between the register file and the PWM generator, whose configuration inputs it drives directly.

## Interface
- `CNT_W`, 16: counter, period and compare width.
- `PRESC_W`, 8: prescaler width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level; 1 runs the timebase.
- `prescale`  in  PRESC_W  tick every `prescale+1` clocks; sampled live.
- `upd_req`  in  1  one-cycle pulse; capture the staging inputs below.
- `period_in`  in  CNT_W  staged period.
- `functions_in`  in  8  staged mode.
- `compare1_in`, `compare2_in`  in  CNT_W  staged compares.
- `pwm_en`  out  1  enable to the generator.
- `count_val`  out  CNT_W  counter value.
- `period`, `functions`, `compare1`, `compare2`  out  active configuration.
- `ovf`  out  1  one-cycle pulse on counter wrap.
- `upd_ack`  out  1  one-cycle pulse when staged values become active.
- `pend`  out  1  a staged update is waiting.
- `irq_en`, `irq_clr`  in  1 each; `irq`  out  1  (see Configuration).

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `pwm_en`=0; `count_val` and prescaler held at 0.
  - Active registers retained.
  - `en`=1 moves to LOAD.
- LOAD (one cycle):
  - If `pend`, copy staging to active, clear `pend`, pulse `upd_ack`.
  - Clear counter and prescaler; go to RUN.
- RUN:
  - `pwm_en`=1.
  - Prescaler counts 0..`prescale`. A tick occurs on the cycle the prescaler equals `prescale`, then the prescaler returns to 0. `prescale`=0 gives a tick every clock.
  - On a tick:
    - If `count_val`==`period`: `count_val`<=0 (wrap) and `ovf` pulses.
    - Otherwise `count_val`+1.
  - The counter spans 0..`period` inclusive: `period+1` ticks per PWM cycle.
- Update handshake:
  - `upd_req` in any state writes all four staging registers and sets `pend`.
  - On a RUN wrap with `pend`=1, the active set is replaced and `upd_ack` pulses.
  - A repeated `upd_req` while pending overwrites staging and produces one ack only.
- Boundary conditions:
  - `upd_req` coincident with a wrap: the wrap applies the old staging contents, the new values are written to staging, and `pend` stays 1. The new values are applied at the next wrap.
  - `period`=0: every tick wraps; `count_val` stays 0.
  - `en` deasserted in RUN: next state IDLE. Counter, prescaler and `pwm_en` clear on that edge. Active registers and `pend` are kept.
  - `rst` mid-operation: immediate return to IDLE. All outputs, active registers, staging and `pend` go to 0.
- Arithmetic: unsigned, CNT_W bits. No wrap beyond `period` is possible because `period` changes only at a wrap or in LOAD.

## Timing
- Reset values: `pwm_en`, `count_val`, `period`, `functions`, `compare1`, `compare2`, `ovf`, `upd_ack`, `pend`, `irq` all 0.
- All outputs are registered.
- Start-up: `en` sampled high at edge k gives LOAD after k. After k+1: RUN, `pwm_en`=1, `count_val`=0. The first increment occurs on the first tick in RUN.
- `ovf`, `upd_ack` and the new active values appear on the same edge that sets `count_val` to 0.
- `pend` clears on that same edge.

## Configuration
- Macro `PWM_TIMEBASE_IRQ_EN`.
- Defined: `irq` is a sticky flag.
  - Set on `ovf` when `irq_en`=1.
  - Cleared by `irq_clr`.
  - Set wins over a simultaneous clear.
- Undefined: ports remain; `irq` is tied 0; `irq_en` and `irq_clr` are ignored.

## Test plan
- Free run:
  - Stimulus: reset, load `period_in`=4 via `upd_req`, `prescale`=0, `en`=1.
  - Response: LOAD pulses `upd_ack`; then `count_val` 0,1,2,3,4,0; `ovf` on each 4→0 edge; `pwm_en`=1 from RUN.
- Prescaler:
  - Stimulus: `prescale`=2, `period`=3.
  - Response: `count_val` advances every 3 clocks; `ovf` every 12 clocks.
- Deferred update:
  - Stimulus: `upd_req` with `period_in`=2 at `count_val`=1 of a 0..4 cycle.
  - Response: `period` stays 4 and `pend`=1 until wrap; `upd_ack` pulses at wrap; then 0,1,2,0.
- Collision:
  - Stimulus: `upd_req` with `compare1_in`=7 on the exact wrap cycle while an earlier update with `compare1_in`=3 is pending.
  - Response: `compare1`=3 after this wrap; `compare1`=7 after the next wrap.
- Disable and reset:
  - Stimulus: drop `en` at `count_val`=3, then `rst` during RUN.
  - Response: dropping `en` gives next-cycle `count_val`=0, `pwm_en`=0 with active config kept. `rst` clears all outputs to 0 asynchronously.
- IRQ (macro defined):
  - Stimulus: `irq_en`=1 with `irq_clr` asserted on a wrap cycle.
  - Response: `irq`=1. A later `irq_clr` alone gives `irq`=0.

Source files
------------

// File: rtl/pwm_timebase_ctrl_if.sv
// rtl/pwm_timebase_ctrl_if.sv - staged-configuration update bus between register file and PWM timebase
//
// Carries one staged configuration set and the update handshake.
//   upd_req       register file -> timebase  one-cycle pulse; capture the *_in values
//   period_in     register file -> timebase  staged period (CNT_W)
//   functions_in  register file -> timebase  staged mode byte
//   compare1_in   register file -> timebase  staged compare 1 (CNT_W)
//   compare2_in   register file -> timebase  staged compare 2 (CNT_W)
//   upd_ack       timebase -> register file  one-cycle pulse when the staged set becomes active
//   pend          timebase -> register file  a staged set is waiting for a period boundary
// master: register-file side; slave: timebase side.

interface pwm_timebase_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             upd_req;
  logic [CNT_W-1:0] period_in;
  logic [7:0]       functions_in;
  logic [CNT_W-1:0] compare1_in;
  logic [CNT_W-1:0] compare2_in;
  logic             upd_ack;
  logic             pend;

  modport master (
    output upd_req,
    output period_in,
    output functions_in,
    output compare1_in,
    output compare2_in,
    input  upd_ack,
    input  pend
  );

  modport slave (
    input  upd_req,
    input  period_in,
    input  functions_in,
    input  compare1_in,
    input  compare2_in,
    output upd_ack,
    output pend
  );

endinterface

// File: rtl/pwm_timebase_ctrl.sv
// rtl/pwm_timebase_ctrl.sv - prescaled PWM period counter with boundary-synchronised configuration updates
//
// Runs the prescaled counter feeding the PWM generator and owns the active
// period/functions/compare1/compare2 set. Software updates are staged and only
// become active in LOAD or when the counter wraps, so a PWM cycle never sees a
// half-applied configuration.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   level; 1 runs the timebase
//   prescale   in   PRESC_W; one counter tick every prescale+1 clocks, sampled live
//   upd        slave modport of pwm_timebase_ctrl_if (staging inputs, upd_ack, pend)
//   pwm_en     out  enable to the generator
//   count_val  out  CNT_W counter value, spans 0..period
//   period     out  active period
//   functions  out  active mode byte
//   compare1   out  active compare 1
//   compare2   out  active compare 2
//   ovf        out  one-cycle pulse on counter wrap
//   irq_en     in   allow ovf to set irq
//   irq_clr    in   clear irq
//   irq        out  sticky overflow flag
//
// Build option: define PWM_TIMEBASE_IRQ_EN to enable the sticky irq flag.
// Without it irq is tied 0 and irq_en/irq_clr are ignored.

module pwm_timebase_ctrl #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PRESC_W-1:0]  prescale,
  pwm_timebase_ctrl_if.slave  upd,
  output logic                pwm_en,
  output logic [CNT_W-1:0]    count_val,
  output logic [CNT_W-1:0]    period,
  output logic [7:0]          functions,
  output logic [CNT_W-1:0]    compare1,
  output logic [CNT_W-1:0]    compare2,
  output logic                ovf,
  input  logic                irq_en,
  input  logic                irq_clr,
  output logic                irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Timebase
  logic [PRESC_W-1:0] presc_q;
  logic [CNT_W-1:0]   count_q;
  logic               pwm_en_q;
  logic               ovf_q;

  // Active configuration
  logic [CNT_W-1:0]   period_q;
  logic [7:0]         functions_q;
  logic [CNT_W-1:0]   compare1_q;
  logic [CNT_W-1:0]   compare2_q;

  // Staging
  logic [CNT_W-1:0]   stg_period_q;
  logic [7:0]         stg_functions_q;
  logic [CNT_W-1:0]   stg_compare1_q;
  logic [CNT_W-1:0]   stg_compare2_q;
  logic               pend_q;
  logic               ack_q;

  // Per-cycle strobes from the next-state logic
  logic               tick;
  logic               wrap;
  logic               apply;
  logic               run_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick     = 1'b0;
    wrap     = 1'b0;
    apply    = 1'b0;
    run_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d  = RUN;
        run_next = 1'b1;
        apply    = pend_q;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          run_next = 1'b1;
          // >= rather than == so a live decrease of prescale below the
          // current prescaler value ticks at once instead of running the
          // prescaler all the way round.
          tick  = (presc_q >= prescale);
          wrap  = tick && (count_q == period_q);
          apply = wrap && pend_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter and prescaler are forced to 0 whenever RUN is being entered or
  // left, which covers IDLE, LOAD and the en-drop edge in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      count_q  <= '0;
      pwm_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pwm_en_q <= run_next;
      ovf_q    <= wrap;
      if (!run_next || state_q != RUN) begin
        presc_q <= '0;
        count_q <= '0;
      end else if (tick) begin
        presc_q <= '0;
        count_q <= wrap ? '0 : count_q + CNT_W'(1);
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

  // The active set is loaded from the staging contents as they were before
  // this edge; a coincident upd_req writes staging afterwards and keeps
  // pend set so its values go out at the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q        <= '0;
      functions_q     <= '0;
      compare1_q      <= '0;
      compare2_q      <= '0;
      stg_period_q    <= '0;
      stg_functions_q <= '0;
      stg_compare1_q  <= '0;
      stg_compare2_q  <= '0;
      pend_q          <= 1'b0;
      ack_q           <= 1'b0;
    end else begin
      ack_q <= apply;
      if (apply) begin
        period_q    <= stg_period_q;
        functions_q <= stg_functions_q;
        compare1_q  <= stg_compare1_q;
        compare2_q  <= stg_compare2_q;
      end
      if (upd.upd_req) begin
        stg_period_q    <= upd.period_in;
        stg_functions_q <= upd.functions_in;
        stg_compare1_q  <= upd.compare1_in;
        stg_compare2_q  <= upd.compare2_in;
        pend_q          <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

`ifdef PWM_TIMEBASE_IRQ_EN
  logic irq_q;

  // Set takes priority over a simultaneous clear so no overflow is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (wrap && irq_en) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = irq_en ^ irq_clr;
  assign irq               = 1'b0;
`endif

  assign pwm_en      = pwm_en_q;
  assign count_val   = count_q;
  assign period      = period_q;
  assign functions   = functions_q;
  assign compare1    = compare1_q;
  assign compare2    = compare2_q;
  assign ovf         = ovf_q;
  assign upd.upd_ack = ack_q;
  assign upd.pend    = pend_q;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// tb/tb_pwm_timebase_ctrl.sv - scoreboard bench for pwm_timebase_ctrl

module tb_pwm_timebase_ctrl;

  localparam int CNT_W   = 16;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic               irq_en = 1'b0;
  logic               irq_clr = 1'b0;

  logic               pwm_en;
  logic [CNT_W-1:0]   count_val;
  logic [CNT_W-1:0]   period;
  logic [7:0]         functions;
  logic [CNT_W-1:0]   compare1;
  logic [CNT_W-1:0]   compare2;
  logic               ovf;
  logic               irq;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_timebase_ctrl_if #(.CNT_W(CNT_W)) upd_bus ();

  pwm_timebase_ctrl #(
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .upd      (upd_bus),
    .pwm_en   (pwm_en),
    .count_val(count_val),
    .period   (period),
    .functions(functions),
    .compare1 (compare1),
    .compare2 (compare2),
    .ovf      (ovf),
    .irq_en   (irq_en),
    .irq_clr  (irq_clr),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             pwm;
    logic [CNT_W-1:0] per;
    logic [7:0]       fn;
    logic [CNT_W-1:0] c1;
    logic [CNT_W-1:0] c2;
    logic             ovf;
    logic             ack;
    logic             pend;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: advanced on each rising edge from the inputs the DUT
  // sees, its post-edge outputs are queued for the negedge monitor.
  int               m_st = 0;
  logic [CNT_W-1:0] m_cnt = '0, m_per = '0, m_c1 = '0, m_c2 = '0;
  logic [CNT_W-1:0] s_per = '0, s_c1 = '0, s_c2 = '0;
  logic [7:0]       m_fn = '0, s_fn = '0;
  logic [PRESC_W-1:0] m_pre = '0;
  logic             m_pwm = 0, m_ovf = 0, m_ack = 0, m_pend = 0, m_irq = 0, m_apply = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st = 0; m_cnt = '0; m_per = '0; m_c1 = '0; m_c2 = '0; m_fn = '0;
        s_per = '0; s_c1 = '0; s_c2 = '0; s_fn = '0; m_pre = '0;
        m_pwm = 0; m_ovf = 0; m_ack = 0; m_pend = 0; m_irq = 0;
        exp_q.delete();
      end else begin
        m_ovf = 0; m_ack = 0; m_apply = 0;
        case (m_st)
          0: begin
            m_cnt = '0; m_pre = '0; m_pwm = 0;
            if (en) m_st = 1;
          end
          1: begin
            m_apply = m_pend; m_cnt = '0; m_pre = '0; m_pwm = 1; m_st = 2;
          end
          default: begin
            if (!en) begin
              m_st = 0; m_cnt = '0; m_pre = '0; m_pwm = 0;
            end else if (m_pre == prescale) begin
              m_pre = '0;
              if (m_cnt == m_per) begin
                m_cnt = '0; m_ovf = 1; m_apply = m_pend;
              end else begin
                m_cnt = m_cnt + 1'b1;
              end
            end else begin
              m_pre = m_pre + 1'b1;
            end
          end
        endcase
        if (m_apply) begin
          m_per = s_per; m_fn = s_fn; m_c1 = s_c1; m_c2 = s_c2;
          m_ack = 1; m_pend = 0;
        end
        if (upd_bus.upd_req) begin
          s_per = upd_bus.period_in; s_fn = upd_bus.functions_in;
          s_c1 = upd_bus.compare1_in; s_c2 = upd_bus.compare2_in;
          m_pend = 1;
        end
`ifdef PWM_TIMEBASE_IRQ_EN
        if (m_ovf && irq_en) m_irq = 1;
        else if (irq_clr) m_irq = 0;
`endif
        e.cnt = m_cnt; e.pwm = m_pwm; e.per = m_per; e.fn = m_fn; e.c1 = m_c1;
        e.c2 = m_c2; e.ovf = m_ovf; e.ack = m_ack; e.pend = m_pend; e.irq = m_irq;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("count_val", count_val, e.cnt);
        check_eq("pwm_en", pwm_en, e.pwm);
        check_eq("period", period, e.per);
        check_eq("functions", functions, e.fn);
        check_eq("compare1", compare1, e.c1);
        check_eq("compare2", compare2, e.c2);
        check_eq("ovf", ovf, e.ovf);
        check_eq("upd_ack", upd_bus.upd_ack, e.ack);
        check_eq("pend", upd_bus.pend, e.pend);
        check_eq("irq", irq, e.irq);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_upd(input logic [15:0] per, input logic [7:0] fn,
                        input logic [15:0] c1, input logic [15:0] c2);
    upd_bus.period_in    = per;
    upd_bus.functions_in = fn;
    upd_bus.compare1_in  = c1;
    upd_bus.compare2_in  = c2;
    upd_bus.upd_req      = 1'b1;
    @(negedge clk);
    upd_bus.upd_req      = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] v);
    bit found = 0;
    for (int i = 0; i < 300; i++) begin
      if (count_val == v) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("wait_count", found, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_count"}, count_val, 0);
    check_eq({tag, "_pwm_en"}, pwm_en, 0);
    check_eq({tag, "_period"}, period, 0);
    check_eq({tag, "_functions"}, functions, 0);
    check_eq({tag, "_compare1"}, compare1, 0);
    check_eq({tag, "_compare2"}, compare2, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
    check_eq({tag, "_upd_ack"}, upd_bus.upd_ack, 0);
    check_eq({tag, "_pend"}, upd_bus.pend, 0);
    check_eq({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    upd_bus.upd_req      = 1'b0;
    upd_bus.period_in    = '0;
    upd_bus.functions_in = '0;
    upd_bus.compare1_in  = '0;
    upd_bus.compare2_in  = '0;
    run(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Free run, period 4, prescale 0; staged set applied in LOAD
    do_upd(16'd4, 8'h5A, 16'd1, 16'd2);
    check_eq("pend_after_req", upd_bus.pend, 1);
    en = 1'b1;
    run(14);

    // Deferred update requested mid-cycle
    wait_count(16'd1);
    do_upd(16'd2, 8'hA5, 16'd5, 16'd6);
    check_eq("deferred_period_held", period, 4);
    check_eq("deferred_pend", upd_bus.pend, 1);
    run(15);

    // Prescaler: tick every 3 clocks, period 3
    en = 1'b0;
    run(2);
    prescale = 8'd2;
    do_upd(16'd3, 8'h11, 16'd1, 16'd2);
    en = 1'b1;
    run(40);
    en = 1'b0;
    run(2);
    prescale = 8'd0;
    en = 1'b1;
    run(3);

    // Collision: new request on the exact wrap cycle
    wait_count(16'd1);
    do_upd(16'd3, 8'h22, 16'd3, 16'd9);
    wait_count(16'd3);
    upd_bus.compare1_in = 16'd7;
    upd_bus.upd_req     = 1'b1;
    @(negedge clk);
    upd_bus.upd_req     = 1'b0;
    check_eq("collision_c1_old", compare1, 3);
    check_eq("collision_pend", upd_bus.pend, 1);
    check_eq("collision_ack", upd_bus.upd_ack, 1);
    check_eq("collision_ovf", ovf, 1);
    wait_count(16'd3);
    @(negedge clk);
    check_eq("collision_c1_new", compare1, 7);
    check_eq("collision_pend_clr", upd_bus.pend, 0);

    // Disable at count 3: no wrap, config kept
    wait_count(16'd3);
    en = 1'b0;
    @(negedge clk);
    check_eq("disable_count", count_val, 0);
    check_eq("disable_pwm_en", pwm_en, 0);
    check_eq("disable_period", period, 3);
    check_eq("disable_compare1", compare1, 7);
    check_eq("disable_ovf", ovf, 0);

    // IRQ: set on wrap wins over a simultaneous clear
    en = 1'b1;
    irq_en = 1'b1;
    run(2);
    wait_count(16'd3);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    irq_en  = 1'b0;
`ifdef PWM_TIMEBASE_IRQ_EN
    check_eq("irq_set_wins", irq, 1);
`else
    check_eq("irq_tied_low", irq, 0);
`endif
    run(2);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check_eq("irq_cleared", irq, 0);

    // Asynchronous reset in RUN, between clock edges
    do_upd(16'd9, 8'h33, 16'd4, 16'd4);
    run(3);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(3);
    check_eq("post_rst_pend", upd_bus.pend, 0);
    check_eq("post_rst_period", period, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
